// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access-size codes,
// FSM state codes and the wait-counter width used by the core's CU/Dextract.
package dmem_ctrl_pkg;

  localparam logic [1:0] MB_WORD = 2'b00;
  localparam logic [1:0] MB_HALF = 2'b01;
  localparam logic [1:0] MB_BYTE = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RWAIT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam int WCNT_W = 3;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Load/store request bus from the core plus the SRAM port, seen from the
// controller (slave) and from whatever drives requests and SRAM data (master).
interface dmem_ctrl_if #(
  parameter int AW    = 10,
  parameter int CNT_W = 16
);

  logic             req_rd;
  logic             req_wr;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [1:0]       mem_byte;
  logic [31:0]      rdata;
  logic             stall;
  logic             misalign;
  logic [CNT_W-1:0] misalign_cnt;
  logic             sram_en;
  logic [3:0]       sram_we;
  logic [AW-1:0]    sram_addr;
  logic [31:0]      sram_wdata;
  logic [31:0]      sram_rdata;

  modport slave (
    input  req_rd, req_wr, addr, wdata, mem_byte, sram_rdata,
    output rdata, stall, misalign, misalign_cnt,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output req_rd, req_wr, addr, wdata, mem_byte, sram_rdata,
    input  rdata, stall, misalign, misalign_cnt,
           sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/dmem_ctrl_byte_lane_gen.sv
// Combinational byte-lane decode: write-enable mask, lane-replicated store
// data and the misalignment flag for one access.
module byte_lane_gen
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  mem_byte,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  we_mask,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  // Size 2'b11 falls into the word branch on purpose.
  always_comb begin
    we_mask    = 4'b1111;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (mem_byte)
      MB_HALF: begin
        we_mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      MB_BYTE: begin
        we_mask    = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      default: begin
        we_mask    = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the single-cycle core and a synchronous
// single-port SRAM: zero-stall stores, READ_LAT-stall loads, misalign filter.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AW       = 10,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
)
(
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        sram_en_s;
  logic [3:0]  sram_we_s;
  logic        stall_s;
  logic [3:0]  we_mask_s;
  logic [31:0] wdata_rep_s;
  logic        misaligned_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^bus.addr[31:AW+2];

  byte_lane_gen u_lane (
    .mem_byte   (bus.mem_byte),
    .addr_lo    (bus.addr[1:0]),
    .wdata      (bus.wdata),
    .we_mask    (we_mask_s),
    .wdata_rep  (wdata_rep_s),
    .misaligned (misaligned_s)
  );

  // Next-state, SRAM strobes and stall; a store wins over a simultaneous load.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    sram_en_s  = 1'b0;
    sram_we_s  = 4'b0000;
    stall_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_rd || bus.req_wr) begin
          if (misaligned_s) begin
            misalign_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              cnt_d = cnt_q;
            end
          end else if (bus.req_wr) begin
            sram_en_s = 1'b1;
            sram_we_s = we_mask_s;
          end else begin
            sram_en_s = 1'b1;
            stall_s   = 1'b1;
            wcnt_d    = WCNT_INIT;
            state_d   = ST_RWAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        stall_s = 1'b1;
        if (wcnt_q == {WCNT_W{1'b0}}) begin
          rdata_d = bus.sram_rdata;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q - {{(WCNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // SRAM port and stall are forced quiet for as long as reset is held.
  always_comb begin
    if (rst) begin
      bus.sram_en    = sram_en_s;
      bus.sram_we    = sram_we_s;
      bus.sram_addr  = bus.addr[AW+1:2];
      bus.sram_wdata = wdata_rep_s;
      bus.stall      = stall_s;
    end else begin
      bus.sram_en    = 1'b0;
      bus.sram_we    = 4'b0000;
      bus.sram_addr  = {AW{1'b0}};
      bus.sram_wdata = 32'h0000_0000;
      bus.stall      = 1'b0;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.misalign     = misalign_q;
  assign bus.misalign_cnt = cnt_q;

  // State, wait counter, load data and misalign bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= {WCNT_W{1'b0}};
      rdata_q    <= 32'h0000_0000;
      misalign_q <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (READ_LAT=2/CNT_W=16 and READ_LAT=1/CNT_W=2)
// against a byte-addressed reference memory and saturating-count model.
module tb_dmem_ctrl;

  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_rd, req_wr;
  logic [31:0] addr, wdata;
  logic [1:0]  mem_byte;
  logic        preload;

  dmem_ctrl_if #(.AW(AW), .CNT_W(16)) ifa ();
  dmem_ctrl_if #(.AW(AW), .CNT_W(2))  ifb ();

  dmem_ctrl #(.AW(AW), .READ_LAT(2), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dmem_ctrl #(.AW(AW), .READ_LAT(1), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.req_rd   = req_rd & ~sel;
  assign ifa.req_wr   = req_wr & ~sel;
  assign ifa.addr     = addr;
  assign ifa.wdata    = wdata;
  assign ifa.mem_byte = mem_byte;
  assign ifb.req_rd   = req_rd & sel;
  assign ifb.req_wr   = req_wr & sel;
  assign ifb.addr     = addr;
  assign ifb.wdata    = wdata;
  assign ifb.mem_byte = mem_byte;

  function automatic logic [31:0] pre_word(input int i);
    return (32'(i) * 32'h9E37_79B9) + 32'h0123_4567;
  endfunction

  // SRAM model shared by both instances, with per-instance read pipelines.
  logic [31:0] mem [0:NW-1];
  logic [31:0] a_p0, a_p1, b_p0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) mem[i] <= pre_word(i);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ifa.sram_en && ifa.sram_we[k]) mem[ifa.sram_addr][8*k +: 8] <= ifa.sram_wdata[8*k +: 8];
        if (ifb.sram_en && ifb.sram_we[k]) mem[ifb.sram_addr][8*k +: 8] <= ifb.sram_wdata[8*k +: 8];
      end
      if (ifa.sram_en && ifa.sram_we == 4'b0000) a_p0 <= mem[ifa.sram_addr];
      if (ifb.sram_en && ifb.sram_we == 4'b0000) b_p0 <= mem[ifb.sram_addr];
    end
    a_p1 <= a_p0;
  end
  assign ifa.sram_rdata = a_p1;
  assign ifb.sram_rdata = b_p0;

  logic        stall_o, en_o, mis_o;
  logic [3:0]  we_o;
  logic [31:0] rdata_o, wd_o, cnt_o, sa_o;
  always_comb begin
    stall_o = sel ? ifb.stall        : ifa.stall;
    en_o    = sel ? ifb.sram_en      : ifa.sram_en;
    mis_o   = sel ? ifb.misalign     : ifa.misalign;
    we_o    = sel ? ifb.sram_we      : ifa.sram_we;
    rdata_o = sel ? ifb.rdata        : ifa.rdata;
    wd_o    = sel ? ifb.sram_wdata   : ifa.sram_wdata;
    cnt_o   = sel ? 32'(ifb.misalign_cnt) : 32'(ifa.misalign_cnt);
    sa_o    = sel ? 32'(ifb.sram_addr)    : 32'(ifa.sram_addr);
  end

  // Reference model state: byte-addressed memory, counters, last load value.
  logic [7:0]  rb [0:4*NW-1];
  int unsigned cnt_ref [2];
  logic [31:0] last_rd [2];
  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] m);
    int size, off, base, n, lat, cmax;
    logic mis;
    logic [3:0]  we_e;
    logic [31:0] wd_e, rd_e;
    size = (m == 2'b01) ? 2 : ((m == 2'b10) ? 1 : 4);
    off  = int'(a[1:0]);
    mis  = (off % size) != 0;
    base = int'(a[11:0]) - off;
    lat  = sel ? 1 : 2;
    cmax = sel ? 3 : 65535;
    we_e = 4'b0000;
    wd_e = 32'h0;
    for (int i = 0; i < 4; i++) begin
      we_e[i]         = (i >= off) && (i < off + size);
      wd_e[8*i +: 8]  = d[8*(i % size) +: 8];
    end
    rd_e = {rb[base+3], rb[base+2], rb[base+1], rb[base]};
    req_rd = rd; req_wr = wr; addr = a; wdata = d; mem_byte = m;
    if (!rd && !wr) begin
      @(negedge clk);
      chk("idle_en", 32'(en_o), 32'h0);
      chk("idle_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
      chk("idle_mis", 32'(mis_o), 32'h0);
    end else if (mis) begin
      @(negedge clk);
      chk("mis_en", 32'(en_o), 32'h0);
      chk("mis_we", 32'(we_o), 32'h0);
      chk("mis_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
      if (cnt_ref[sel] < cmax) cnt_ref[sel]++;
      chk("mis_pulse", 32'(mis_o), 32'h1);
      chk("mis_cnt", cnt_o, cnt_ref[sel]);
      chk("mis_stale", rdata_o, last_rd[sel]);
    end else if (wr) begin
      @(negedge clk);
      chk("st_en", 32'(en_o), 32'h1);
      chk("st_we", 32'(we_o), 32'(we_e));
      chk("st_wdata", wd_o, wd_e);
      chk("st_addr", sa_o, 32'(a[11:2]));
      chk("st_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
      for (int k = 0; k < size; k++) rb[base + off + k] = d[8*k +: 8];
      req_rd = 1'b0; req_wr = 1'b0;
      #1;
      chk("st_nowait", 32'(stall_o), 32'h0);
      chk("st_nomis", 32'(mis_o), 32'h0);
    end else begin
      @(negedge clk);
      chk("ld_en", 32'(en_o), 32'h1);
      chk("ld_we", 32'(we_o), 32'h0);
      chk("ld_stall0", 32'(stall_o), 32'h1);
      chk("ld_addr", sa_o, 32'(a[11:2]));
      @(posedge clk); #1;
      chk("ld_nomis", 32'(mis_o), 32'h0);
      n = 0;
      while (stall_o && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      chk("ld_stall_len", 32'(n), 32'(lat));
      chk("ld_rdata", rdata_o, rd_e);
      last_rd[sel] = rd_e;
      @(negedge clk);
      chk("done_en", 32'(en_o), 32'h0);
      chk("done_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
    end
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; preload = 1'b1; sel = 1'b0;
    req_rd = 1'b0; req_wr = 1'b1; addr = 32'h4; wdata = 32'hFFFF_FFFF; mem_byte = 2'b00;
    for (int i = 0; i < NW; i++)
      for (int k = 0; k < 4; k++) rb[4*i + k] = pre_word(i)[8*k +: 8];
    cnt_ref[0] = 0; cnt_ref[1] = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(en_o), 32'h0);
    chk("rst_we", 32'(we_o), 32'h0);
    chk("rst_saddr", sa_o, 32'h0);
    chk("rst_swdata", wd_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_cnt", cnt_o, 32'h0);
    chk("rst_mis", 32'(mis_o), 32'h0);
    req_wr = 1'b0;
    @(posedge clk); #1;
    preload = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases on the READ_LAT=2 instance.
    op(1'b0, 1'b1, 32'h13, 32'h0000_00A5, 2'b10);
    op(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 2'b00);
    op(1'b1, 1'b0, 32'h8, 32'h0, 2'b00);
    chk("ld_deadbeef", last_rd[0], 32'hDEAD_BEEF);
    op(1'b1, 1'b0, 32'h10, 32'h0, 2'b00);
    op(1'b1, 1'b1, 32'h0, 32'h1234_5678, 2'b01);
    op(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    op(1'b1, 1'b0, 32'h5, 32'h0, 2'b01);
    op(1'b0, 1'b1, 32'h6, 32'h0BAD_F00D, 2'b00);
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    chk("mis_cnt_two", cnt_o, 32'd2);
    op(1'b0, 1'b1, 32'h2, 32'h0000_BEEF, 2'b11);
    op(1'b0, 1'b1, 32'hFFFF_F00A, 32'h0000_C0DE, 2'b01);
    op(1'b1, 1'b0, 32'h8, 32'h0, 2'b00);

    // READ_LAT=1 instance: back-to-back loads and counter saturation.
    sel = 1'b1;
    @(posedge clk); #1;
    op(1'b0, 1'b1, 32'h0, 32'h1111_2222, 2'b00);
    op(1'b0, 1'b1, 32'h4, 32'h3333_4444, 2'b00);
    op(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    op(1'b1, 1'b0, 32'h4, 32'h0, 2'b00);
    chk("b2b_second", last_rd[1], 32'h3333_4444);
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 32'h1 + 32'(2*i) * 32'h4, 32'h0, 2'b01);
    chk("cnt_sat", cnt_o, 32'd3);

    // Random traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++)
        op(1'(($urandom % 3) == 0), 1'(($urandom % 2) == 0), $urandom,
           $urandom, 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a READ_LAT=2 load.
    sel = 1'b0;
    @(posedge clk); #1;
    req_rd = 1'b1; req_wr = 1'b0; addr = 32'h8; mem_byte = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", 32'(stall_o), 32'h0);
    chk("mid_rst_rdata", rdata_o, 32'h0);
    chk("mid_rst_en", 32'(en_o), 32'h0);
    chk("mid_rst_cnt", cnt_o, 32'h0);
    req_rd = 1'b0;
    cnt_ref[0] = 0; cnt_ref[1] = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    op(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 2'b00);
    op(1'b1, 1'b0, 32'h20, 32'h0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
